// File: rtl/display_scanner_if.sv
// Bus bundle for display_scanner: load request, digit data and the scan outputs.
// The master side drives load/digits_in; the slave side drives the display outputs.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [3*NUM_DIGITS-1:0] digits_in;
    logic [2:0]              number;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    frame_done;
    logic                    load_pending;

    modport master (
        output load,
        output digits_in,
        input  number,
        input  anodes,
        input  frame_done,
        input  load_pending
    );

    modport slave (
        input  load,
        input  digits_in,
        output number,
        output anodes,
        output frame_done,
        output load_pending
    );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed digit scanner with double-buffered, tear-free digit loading.
// A prescaler divides the clock into digit slots; a frame is NUM_DIGITS slots.
// New digit data is held in a pending buffer and only moved into the display
// buffer at a frame wrap, so a frame never shows a mix of old and new digits.
// Optional feature: define SCAN_BLANKING_EN to blank all anodes for the first
// BLANK_CYCLES cycles of every slot (dead time). Without it BLANK_CYCLES is unused.
module display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input logic              clock,
    input logic              resetn,
    display_scanner_if.slave bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
`ifdef SCAN_BLANKING_EN
    localparam logic [PRE_W-1:0] BLANK_LIM = PRE_W'(BLANK_CYCLES);
`endif

    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [3*NUM_DIGITS-1:0] display_q, display_d;
    logic [3*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    loadPending_q, loadPending_d;
    logic [2:0]              number_q, number_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    frameDone_q, frameDone_d;
    logic                    slotTick;
    logic                    frameWrap;

    // Slot/frame timing and the double-buffer handoff at the frame wrap.
    always_comb begin
        slotTick  = (prescaler_q == PRE_MAX);
        frameWrap = slotTick && (index_q == IDX_MAX);

        prescaler_d = slotTick ? '0 : prescaler_q + 1'b1;

        index_d = index_q;
        if (slotTick) begin
            index_d = (index_q == IDX_MAX) ? '0 : index_q + 1'b1;
        end

        // The display takes the data that was pending before this edge; a load
        // in the same cycle simply becomes the next pending frame.
        display_d = (frameWrap && loadPending_q) ? pending_q : display_q;
        pending_d = bus.load ? bus.digits_in : pending_q;

        loadPending_d = loadPending_q;
        if (bus.load) begin
            loadPending_d = 1'b1;
        end else if (frameWrap) begin
            loadPending_d = 1'b0;
        end

        frameDone_d = frameWrap;
    end

    // Output decode from the current index, display buffer and prescaler.
    always_comb begin
        number_d = 3'd0;
        anodes_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_q == IDX_W'(k)) begin
                number_d    = display_q[3*k +: 3];
                anodes_d[k] = 1'b0;
            end
        end
`ifdef SCAN_BLANKING_EN
        if (prescaler_q < BLANK_LIM) begin
            anodes_d = '1;
        end
`endif
    end

    // State and registered outputs; reset drops any pending data outright.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            display_q     <= '0;
            pending_q     <= '0;
            loadPending_q <= 1'b0;
            number_q      <= 3'd0;
            anodes_q      <= '1;
            frameDone_q   <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            loadPending_q <= loadPending_d;
            number_q      <= number_d;
            anodes_q      <= anodes_d;
            frameDone_q   <= frameDone_d;
        end
    end

    assign bus.number       = number_q;
    assign bus.anodes       = anodes_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.load_pending = loadPending_q;
endmodule
